// File: rtl/cam_wr_pkg.sv
// Shared constants and FSM encoding for the camera frame write packer.
package cam_wr_pkg;
   localparam int PIX_W        = 16;
   localparam int PIX_PER_WORD = 8;
   localparam int WORD_W       = PIX_W * PIX_PER_WORD;
   localparam int CNT_W        = $clog2(PIX_PER_WORD);

   typedef enum logic [0:0] {
      WAIT_VS = 1'b0,
      ACTIVE  = 1'b1
   } state_t;
endpackage

// File: rtl/cam_wr_fifo.sv
// Occupancy-counted synchronous FIFO with a registered head. A pushed entry becomes visible
// at the head one cycle after it is written. A push is accepted when full if the head pops in the same cycle.
module cam_wr_fifo #(
   parameter int W     = 153,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_pop
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [PW:0]   r_count;
   logic [PW:0]   w_avail;
   logic          r_valid;
   logic [W-1:0]  r_head;
   logic          w_pop;
   logic          w_full;
   logic          w_wr_en;

   assign w_pop        = r_valid & i_ready;
   assign w_full       = (r_count == FULL_CNT);
   assign w_wr_en      = i_push & (~w_full | w_pop);
   assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
   // entries already stored before this cycle's push, minus the one leaving
   assign w_avail      = r_count - (PW+1)'(w_pop);

   // storage array
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

   // pointers, occupancy and registered head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {(PW+1){1'b0}};
         r_valid  <= 1'b0;
         r_head   <= {W{1'b0}};
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1'b1);
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_avail + (PW+1)'(w_wr_en);
         r_valid  <= (w_avail != {(PW+1){1'b0}});
         if (w_avail != {(PW+1){1'b0}}) r_head <= r_mem[w_rd_ptr_nxt];
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_head;
   assign o_full  = w_full;
   assign o_pop   = w_pop;
endmodule

// File: rtl/cam_frame_wr_packer.sv
// Packs camera rgb565 pixels into 128-bit words with double-buffered frame addresses for the DDR writer.
// Optional CAM_WR_TEST_PATTERN_EN adds test_en, substituting a per-frame pixel counter for pdata_i.
module cam_frame_wr_packer
   import cam_wr_pkg::*;
#(
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
   parameter logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(24'd115200),
   parameter int                FIFO_DEPTH  = 16
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              vs_i,
   input  logic              de_i,
   input  logic [PIX_W-1:0]  pdata_i,
`ifdef CAM_WR_TEST_PATTERN_EN
   input  logic              test_en,
`endif
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [WORD_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_sof,
   output logic              frame_done,
   output logic              buf_sel,
   output logic              ovf
);
   localparam int FIFO_W = WORD_W + ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PIX_PER_WORD - 1);

   state_t                                r_state;
   logic                                  r_vs_q;
   logic                                  w_rise;
   logic [CNT_W-1:0]                      r_cnt;
   logic [PIX_PER_WORD-1:0][PIX_W-1:0]    r_lanes;
   logic [PIX_PER_WORD-1:0][PIX_W-1:0]    w_lanes;
   logic [PIX_W-1:0]                      w_pix;
   logic                                  w_word_done;
   logic [ADDR_W-1:0]                     r_addr;
   logic                                  r_sof_pend;
   logic                                  r_push;
   logic [FIFO_W-1:0]                     r_push_word;
   logic                                  r_frame_done;
   logic                                  r_buf_sel;
   logic                                  r_ovf;
   logic                                  w_full;
   logic                                  w_pop;
   logic                                  w_head_valid;
   logic [FIFO_W-1:0]                     w_head;

   assign w_rise = vs_i & ~r_vs_q;

`ifdef CAM_WR_TEST_PATTERN_EN
   logic [PIX_W-1:0] r_tp_cnt;

   // pattern counter restarts each frame and advances per accepted pixel
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)                            r_tp_cnt <= {PIX_W{1'b0}};
      else if (w_rise)                       r_tp_cnt <= {PIX_W{1'b0}};
      else if ((r_state == ACTIVE) && de_i)  r_tp_cnt <= r_tp_cnt + PIX_W'(1'b1);
      else                                   r_tp_cnt <= r_tp_cnt;
   end

   assign w_pix = test_en ? r_tp_cnt : pdata_i;
`else
   assign w_pix = pdata_i;
`endif

   // lane image including the current pixel, and end-of-word detection
   always_comb begin
      w_lanes = r_lanes;
      if (de_i) w_lanes[r_cnt] = w_pix;
      else      w_lanes = r_lanes;
      w_word_done = (r_state == ACTIVE) & ~w_rise &
                    ((de_i & (r_cnt == LAST_LANE)) | (~de_i & (r_cnt != {CNT_W{1'b0}})));
   end

   // frame FSM, packing, addressing and status flags
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= WAIT_VS;
         r_vs_q       <= 1'b0;
         r_cnt        <= {CNT_W{1'b0}};
         r_lanes      <= {WORD_W{1'b0}};
         r_addr       <= {ADDR_W{1'b0}};
         r_sof_pend   <= 1'b0;
         r_push       <= 1'b0;
         r_push_word  <= {FIFO_W{1'b0}};
         r_frame_done <= 1'b0;
         r_buf_sel    <= 1'b1;
         r_ovf        <= 1'b0;
      end else begin
         r_vs_q       <= vs_i;
         r_push       <= 1'b0;
         r_frame_done <= 1'b0;
         if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
         // frame start wins over any pixel or line end in the same cycle
         if (w_rise) begin
            r_state      <= ACTIVE;
            r_frame_done <= (r_state == ACTIVE);
            r_buf_sel    <= ~r_buf_sel;
            r_addr       <= r_buf_sel ? BASE_ADDR : BASE_ADDR + FRAME_WORDS;
            r_cnt        <= {CNT_W{1'b0}};
            r_lanes      <= {WORD_W{1'b0}};
            r_sof_pend   <= 1'b1;
         end else if (w_word_done) begin
            r_push       <= 1'b1;
            r_push_word  <= {r_sof_pend, r_addr, w_lanes};
            r_addr       <= r_addr + ADDR_W'(1'b1);
            r_sof_pend   <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
            r_lanes      <= {WORD_W{1'b0}};
         end else if ((r_state == ACTIVE) && de_i) begin
            r_lanes      <= w_lanes;
            r_cnt        <= r_cnt + CNT_W'(1'b1);
         end
      end
   end

   cam_wr_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (pclk),
      .rst_n   (rst_n),
      .i_push  (r_push),
      .i_data  (r_push_word),
      .i_ready (wr_ready),
      .o_valid (w_head_valid),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_pop   (w_pop)
   );

   assign wr_valid   = w_head_valid;
   assign wr_data    = w_head[WORD_W-1:0];
   assign wr_addr    = w_head[WORD_W +: ADDR_W];
   assign wr_sof     = w_head[FIFO_W-1];
   assign frame_done = r_frame_done;
   assign buf_sel    = r_buf_sel;
   assign ovf        = r_ovf;
endmodule
